// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control unit: opcode constants
// and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SUBI  = 6'b001001;
    localparam logic [5:0] OP_LWI   = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: jump target, taken branch, or sequential.
module pc_next
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_offset,
    input  logic            i_branch,
    input  logic            i_jump,
    input  logic            i_zero,
    output logic [PC_W-1:0] o_next_pc
);

    logic [PC_W-1:0] w_seq_pc;

    assign w_seq_pc = i_pc + {{(PC_W-1){1'b0}}, 1'b1};

    // The offset is already PC_W wide, so its sign extension to PC_W is the
    // field itself; modulo-2^PC_W addition makes negative offsets wrap.
    always_comb begin
        if (i_jump) begin
            o_next_pc = i_offset;
        end else if (i_branch && i_zero) begin
            o_next_pc = w_seq_pc + i_offset;
        end else begin
            o_next_pc = w_seq_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: FETCH -> WAIT (memory ack) -> ISSUE (decode handshake),
// updating the PC from the control-unit branch/jump decision at handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    input  logic               branch,
    input  logic               jump,
    input  logic               zero
);

    fetch_state_t       r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    w_next_pc;

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .i_pc      (r_pc),
        .i_offset  (r_instr[PC_W-1:0]),
        .i_branch  (branch),
        .i_jump    (jump),
        .i_zero    (zero),
        .o_next_pc (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_WAIT;
                S_WAIT: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (instr_ready) begin
                        r_pc    <= w_next_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Request is gated by reset so memory sees no fetch while rst_n is low.
    assign imem_req    = rst_n && (r_state != S_ISSUE);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_ISSUE);
    assign instr       = r_instr;
    assign pc          = r_pc;

endmodule
